// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_tx byte channel between NUM_REQ requesters. The channel is
// granted round-robin, and each grant is held for a whole packet (terminated
// by req_last), so bytes from different sources never interleave. The data,
// valid and ready paths are combinational through the grant mux. The grant
// and FSM state are registered.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   When defined, a grant is revoked if the owner keeps req_valid low for
//   TIMEOUT_CYCLES consecutive XFER cycles. In that case timeout pulses for
//   one cycle. When the macro is undefined, timeout is tied low.
//
// Parameters
//   NUM_REQ         number of requesters (2..8)
//   TIMEOUT_CYCLES  stall limit in clk cycles (timeout build only)
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   req_data       byte of requester i on bits [i*8 +: 8]
//   req_valid      requester i presents a byte
//   req_last       presented byte ends its packet (qualified by req_valid)
//   req_ready      byte of requester i accepted this cycle
//   tx_data        byte to uart_tx
//   tx_data_valid  valid to uart_tx
//   tx_data_ready  ready from uart_tx
//   grant          one-hot current owner, zero when idle
//   busy           a packet is in progress
//   timeout        one-cycle pulse when a grant is revoked by stall timeout
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 27_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    input  logic                 tx_data_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_ptr_q, last_ptr_d;

    logic [7:0] own_data;
    logic       own_valid;
    logic       own_last;

    // First requesting index found searching upward from ptr+1, with wrap.
    // The previous owner (ptr itself) is searched last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [IDX_W-1:0] ptr,
                                                 input logic [NUM_REQ-1:0] vld);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && vld[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Owner mux: selects the byte, valid and last flag of the current owner.
    always_comb begin
        own_data  = 8'h00;
        own_valid = 1'b0;
        own_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                own_data  = req_data[i*8 +: 8];
                own_valid = req_valid[i];
                own_last  = req_last[i];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             timeout_q, timeout_d;

    assign timeout = timeout_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_ptr_d = last_ptr_q;
`ifdef UART_ARB_TIMEOUT_EN
        stall_cnt_d = stall_cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d = XFER;
                    owner_d = rr_pick(last_ptr_q, req_valid);
                end
            end
            XFER: begin
                if (own_valid && tx_data_ready && own_last) begin
                    state_d    = IDLE;
                    last_ptr_d = owner_q;
                end
`ifdef UART_ARB_TIMEOUT_EN
                // Only cycles where the owner has nothing to offer count as
                // stalls. A channel held off by tx_data_ready is not a stall.
                if (own_valid) begin
                    stall_cnt_d = '0;
                end else if (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = IDLE;
                    last_ptr_d  = owner_q;
                    timeout_d   = 1'b1;
                    stall_cnt_d = '0;
                end else begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_ptr_q <= IDX_W'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_ptr_q <= last_ptr_d;
`ifdef UART_ARB_TIMEOUT_EN
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    // Grant decode and combinational channel path
    assign busy = (state_q == XFER);

    always_comb begin
        grant         = '0;
        req_ready     = '0;
        tx_data       = 8'h00;
        tx_data_valid = 1'b0;
        if (state_q == XFER) begin
            grant[owner_q]     = 1'b1;
            tx_data            = own_data;
            tx_data_valid      = own_valid;
            req_ready[owner_q] = tx_data_ready & own_valid;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter with four requesters. Each requester
// is fed from a byte queue. The queue entries are {last, data}. Every byte
// transferred on the channel is logged as {owner, last, data}. The expected
// logs are built from the channel rules at packet level: whole packets,
// with owners taken round-robin among those with packets pending.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_data_valid;
    logic           tx_data_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .grant         (grant),
        .busy          (busy),
        .timeout       (timeout)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0]  src_q [N][$];   // per requester: {last, data}
    logic [10:0] out_q [$];      // observed transfers: {owner[1:0], last, data}
    logic [N-1:0] hold;          // force requester valid low
    logic [N-1:0] accepted;
    logic         ready_ctl;
    logic         rand_ready;
    logic         prev_last_xfer;
    logic         prev_idle_req;
    int           proto_err;     // per-cycle channel rule violations

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && !hold[i]) begin
                req_valid[i]      = 1'b1;
                req_data[i*8 +: 8] = src_q[i][0][7:0];
                req_last[i]       = src_q[i][0][8];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
        tx_data_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_ctl;
    endtask

    task automatic observe();
        int   owner;
        logic xfer;
        owner = -1;
        for (int i = 0; i < N; i++) if (grant[i]) owner = i;
        xfer = tx_data_valid & tx_data_ready;
        if (prev_last_xfer && busy) proto_err++;
        if (prev_idle_req && !busy) proto_err++;
        if (busy && !$onehot(grant)) proto_err++;
        if (!busy && (grant != '0 || tx_data_valid || req_ready != '0 || tx_data != 8'h00))
            proto_err++;
        if (busy && owner >= 0) begin
            if (tx_data_valid !== req_valid[owner]) proto_err++;
            if (tx_data !== req_data[owner*8 +: 8]) proto_err++;
            if (req_ready !== (N'(tx_data_ready & req_valid[owner]) << owner)) proto_err++;
        end
        if (xfer && owner >= 0) out_q.push_back({2'(owner), req_last[owner], tx_data});
        prev_last_xfer = xfer && (owner >= 0) && req_last[owner];
        prev_idle_req  = !busy && (req_valid != '0);
        accepted       = req_ready;
    endtask

    // One clock: consume accepted bytes, present new inputs, sample at negedge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (accepted[i]) void'(src_q[i].pop_front());
        drive();
        @(negedge clk);
        observe();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        out_q.delete();
        hold = '0; accepted = '0; ready_ctl = 1'b1; rand_ready = 1'b0;
        prev_last_xfer = 1'b0; prev_idle_req = 1'b0; proto_err = 0;
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add_pkt(input int r, input int len, input logic [7:0] base);
        for (int b = 0; b < len; b++) src_q[r].push_back({(b == len - 1), 8'(base + b)});
    endtask

    task automatic run_until_out(input int n, input string name);
        int cyc = 0;
        while (out_q.size() < n && cyc < 3000) begin tick(); cyc++; end
        checks++;
        if (out_q.size() < n) begin
            errors++;
            $display("FAIL %s wait: transfers %0d, required %0d", name, out_q.size(), n);
        end
    endtask

    task automatic run_drain(input string name);
        int   cyc = 0;
        logic pend;
        pend = 1'b1;
        while (pend && cyc < 5000) begin
            tick(); cyc++;
            pend = busy;
            for (int i = 0; i < N; i++) if (src_q[i].size() > 0) pend = 1'b1;
        end
        checks++;
        if (pend) begin
            errors++;
            $display("FAIL %s drain: not idle after %0d cycles", name, cyc);
        end
    endtask

    task automatic check_log(input string name, input logic [10:0] exp_q [$]);
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s count: got %0d bytes, required %0d", name, out_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) begin
            checks++;
            if (out_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL %s byte%0d: got owner%0d last%0b %02h, required owner%0d last%0b %02h",
                         name, k, out_q[k][10:9], out_q[k][8], out_q[k][7:0],
                         exp_q[k][10:9], exp_q[k][8], exp_q[k][7:0]);
            end
        end
        checks++;
        if (proto_err != 0) begin
            errors++;
            $display("FAIL %s protocol: %0d rule violations, required 0", name, proto_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, busy, req_ready, tx_data, tx_data_valid, timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got grant=%b busy=%b ready=%b data=%h vld=%b to=%b, required all 0",
                     grant, busy, req_ready, tx_data, tx_data_valid, timeout);
        end
        do_reset();
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || grant !== '0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b grant=%b, required 0/0000", busy, grant);
        end
    endtask

    task automatic test_single_packet();
        logic [N-1:0] exp_g [5];
        logic [7:0]   exp_d [5];
        exp_g = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        exp_d = '{8'h00, 8'h41, 8'h42, 8'h43, 8'h00};
        do_reset();
        add_pkt(0, 3, 8'h41);
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (grant !== exp_g[k] || busy !== (exp_g[k] != '0) || tx_data !== exp_d[k]) begin
                errors++;
                $display("FAIL single cycle%0d: got grant=%b busy=%b data=%h, required grant=%b busy=%b data=%h",
                         k, grant, busy, tx_data, exp_g[k], (exp_g[k] != '0), exp_d[k]);
            end
        end
    endtask

    task automatic test_all_simultaneous();
        logic [10:0] exp_q [$];
        do_reset();
        for (int i = 0; i < N; i++) add_pkt(i, 2, 8'(8'h10 * i + 1));
        for (int i = 0; i < N; i++) begin
            exp_q.push_back({2'(i), 1'b0, 8'(8'h10 * i + 1)});
            exp_q.push_back({2'(i), 1'b1, 8'(8'h10 * i + 2)});
        end
        run_drain("simul");
        check_log("simul", exp_q);
    endtask

    task automatic test_fairness();
        logic [10:0] exp_q [$];
        do_reset();
        add_pkt(2, 2, 8'h20);
        add_pkt(2, 2, 8'h30);
        run_until_out(2, "fair");
        add_pkt(1, 2, 8'h50);
        run_drain("fair");
        exp_q = '{{2'd2, 1'b0, 8'h20}, {2'd2, 1'b1, 8'h21},
                  {2'd1, 1'b0, 8'h50}, {2'd1, 1'b1, 8'h51},
                  {2'd2, 1'b0, 8'h30}, {2'd2, 1'b1, 8'h31}};
        check_log("fair", exp_q);
    endtask

    task automatic test_stall();
        logic [10:0] exp_q [$];
        int bad = 0;
        do_reset();
        add_pkt(3, 5, 8'h61);
        run_until_out(2, "stall");
        ready_ctl = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (tx_data !== 8'h63 || tx_data_valid !== 1'b1 || req_ready !== '0 || grant !== 4'b1000)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: %0d cycles not holding byte 63 valid with ready 0, required 0", bad);
        end
        ready_ctl = 1'b1;
        run_drain("stall");
        for (int b = 0; b < 5; b++) exp_q.push_back({2'd3, (b == 4), 8'(8'h61 + b)});
        check_log("stall", exp_q);
    endtask

    task automatic test_random();
        logic [8:0]  cp [N][$];
        logic [10:0] exp_q [$];
        int   ptr, idx, len, npk;
        logic any;
        do_reset();
        for (int i = 0; i < N; i++) begin
            npk = (i == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
            for (int p = 0; p < npk; p++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) src_q[i].push_back({(b == len - 1), 8'($urandom)});
            end
            cp[i] = src_q[i];
        end
        // Packet-level round-robin among requesters that still hold packets.
        ptr = N - 1;
        any = 1'b1;
        while (any) begin
            idx = -1;
            for (int k = 1; k <= N; k++)
                if (idx < 0 && cp[(ptr + k) % N].size() > 0) idx = (ptr + k) % N;
            if (idx < 0) begin
                any = 1'b0;
            end else begin
                logic [8:0] e;
                do begin
                    e = cp[idx].pop_front();
                    exp_q.push_back({2'(idx), e});
                end while (!e[8]);
                ptr = idx;
            end
        end
        rand_ready = 1'b1;
        run_drain("random");
        check_log("random", exp_q);
    endtask

    task automatic test_owner_drop();
        logic [10:0] exp_q [$];
        int bad = 0;
        do_reset();
        add_pkt(1, 3, 8'hA1);
        add_pkt(2, 1, 8'hB1);
        run_until_out(1, "drop");
        hold[1] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (grant !== 4'b0010 || tx_data_valid !== 1'b0 || req_ready !== '0 || timeout !== 1'b0)
                bad++;
        end
`ifdef UART_ARB_TIMEOUT_EN
        tick();
        checks++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_timeout: got timeout=%b busy=%b, required 1/0", timeout, busy);
        end
        src_q[1].delete();
        hold = '0;
        run_drain("drop");
        exp_q = '{{2'd1, 1'b0, 8'hA1}, {2'd2, 1'b1, 8'hB1}};
`else
        for (int k = 17; k <= 40; k++) begin
            tick();
            if (grant !== 4'b0010 || tx_data_valid !== 1'b0 || timeout !== 1'b0) bad++;
        end
        hold = '0;
        run_drain("drop");
        exp_q = '{{2'd1, 1'b0, 8'hA1}, {2'd1, 1'b0, 8'hA2}, {2'd1, 1'b1, 8'hA3},
                  {2'd2, 1'b1, 8'hB1}};
`endif
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL drop_hold: %0d stalled cycles with wrong grant/valid/timeout, required 0", bad);
        end
        check_log("drop", exp_q);
    endtask

    task automatic test_reset_midpacket();
        logic [10:0] exp_q [$];
        do_reset();
        add_pkt(0, 1, 8'h01);
        add_pkt(1, 3, 8'h11);
        run_until_out(3, "rstmid");
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, busy, req_ready, tx_data, tx_data_valid, timeout} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got grant=%b busy=%b ready=%b data=%h vld=%b, required all 0",
                     grant, busy, req_ready, tx_data, tx_data_valid);
        end
        do_reset();
        add_pkt(0, 1, 8'h55);
        add_pkt(3, 1, 8'h66);
        run_drain("rstmid");
        exp_q = '{{2'd0, 1'b1, 8'h55}, {2'd3, 1'b1, 8'h66}};
        check_log("rstmid", exp_q);
    endtask

    initial begin
        req_data = '0; req_valid = '0; req_last = '0; tx_data_ready = 1'b1;
        hold = '0; accepted = '0; ready_ctl = 1'b1; rand_ready = 1'b0;
        prev_last_xfer = 1'b0; prev_idle_req = 1'b0; proto_err = 0;
        test_reset();
        test_single_packet();
        test_all_simultaneous();
        test_fairness();
        test_stall();
        for (int r = 0; r < 5; r++) test_random();
        test_owner_drop();
        test_reset_midpacket();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
